// File: rtl/timer_pkg.sv
// Shared types and defaults for the single-counter timeout scheduler.
package timer_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 25;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Index width that stays legal when only one requester exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the index after i_last.
module rr_arbiter
  import timer_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_pick,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  logic [IW-1:0] w_cand [N_REQ];

  // w_cand[j] is the j-th index visited, starting just past the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand[gi] = IW'((int'(i_last) + gi + 1) % N_REQ);
    end
  endgenerate

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!o_valid && i_req[w_cand[j]]) begin
        o_valid           = 1'b1;
        o_idx             = w_cand[j];
        o_pick[w_cand[j]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// One shared down-counter time-sliced between N_REQ requesters via round-robin.
module timer_sched
  import timer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_time,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy
);

  localparam int IW = idx_width(N_REQ);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [IW-1:0]    r_last;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;

  logic [N_REQ-1:0] w_pick;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic [WIDTH-1:0] w_time_sel;
  logic [WIDTH-1:0] w_load;
  logic             w_held;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req  (i_req),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  assign w_time_sel = i_time[w_idx*WIDTH +: WIDTH];
  // A zero duration still gets one grant cycle, so cnt never starts at 0.
  assign w_load     = (w_time_sel == '0) ? WIDTH'(1) : w_time_sel;
  // r_last already holds the owner while a timeout is running.
  assign w_held     = i_req[r_last];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_last  <= IW'(N_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_valid) begin
            r_state <= RUN;
            r_cnt   <= w_load;
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_last  <= w_idx;
          end
        end
        RUN: begin
          if (!w_held) begin
            // Withdrawal wins even on the final count: no done pulse.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == WIDTH'(1)) begin
            r_state <= DONE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= r_grant;
          end else begin
            r_cnt <= r_cnt - WIDTH'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

endmodule
